// File: rtl/gc_sched_pkg.sv
// Shared types and helpers for the TDM slot scheduler.
package gc_sched_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_PER_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

  // Reflected binary Gray code; callers size the result to their counter.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gc_rr_arb.sv
// Round-robin arbiter: searches upward from the pointer and moves the
// pointer past the winner whenever the caller commits a grant.
module gc_rr_arb #(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             advance,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant_next
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] pointer_q;
  logic [PTR_W-1:0] pointer_d;

  // First requester at or above the pointer, wrapping modulo N_REQ.
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    found      = 1'b0;
    idx        = '0;
    grant_next = '0;
    pointer_d  = pointer_q;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((int'(pointer_q) + k) % N_REQ);
      if (!found && req[idx]) begin
        found           = 1'b1;
        grant_next[idx] = 1'b1;
        pointer_d       = (idx == PTR_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  // Pointer only moves when a grant is actually registered; no request
  // leaves it where it was.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pointer_q <= '0;
    end else if (clear) begin
      pointer_q <= '0;
    end else if (advance) begin
      pointer_q <= pointer_d;
    end
  end

endmodule

// File: rtl/gc_slot_sched.sv
// TDM slot scheduler: clock divider, frame slot counter (binary + Gray)
// and a round-robin owner per slot.
module gc_slot_sched
  import gc_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_REQ = DEF_N_REQ,
  parameter int PER_W = DEF_PER_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic [PER_W-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_last_slot,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [WIDTH-1:0] slot_bin,
  output logic [WIDTH-1:0] slot_gc,
  output logic             slot_stb,
  output logic             frame_stb,
  output logic             busy
);

  sched_state_e     state_q, state_d;
  logic [PER_W-1:0] div_q, div_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] slot_q, slot_d;
  logic [WIDTH-1:0] gc_q;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             stb_q, stb_d;
  logic             frame_q, frame_d;
  logic             advance;
  logic             terminal;
  logic             at_last;
  logic             draining;
  logic [N_REQ-1:0] arb_grant;

  gc_rr_arb #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (clear),
    .advance    (advance),
    .req        (req),
    .grant_next (arb_grant)
  );

  assign terminal = (div_q == per_q);
  assign at_last  = (slot_q == last_q);
  // A stop seen on the final cycle of slot L still closes this frame.
  assign draining = (state_q == DRAIN) || stop;

  // Next-state logic for FSM, divider, slot counter, strobes and grant.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    per_d   = per_q;
    last_d  = last_q;
    slot_d  = slot_q;
    grant_d = grant_q;
    stb_d   = 1'b0;
    frame_d = 1'b0;
    advance = 1'b0;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (start && !stop) begin
          state_d = RUN;
          per_d   = cfg_period;
          last_d  = cfg_last_slot;
          div_d   = '0;
          slot_d  = '0;
          stb_d   = 1'b1;
          frame_d = 1'b1;
          grant_d = arb_grant;
          advance = 1'b1;
        end
      end
      RUN, DRAIN: begin
        if (state_q == RUN && stop) begin
          state_d = DRAIN;
        end
        if (terminal) begin
          div_d = '0;
          if (at_last && draining) begin
            state_d = IDLE;
            slot_d  = '0;
            grant_d = '0;
          end else begin
            slot_d  = at_last ? '0 : slot_q + 1'b1;
            stb_d   = 1'b1;
            frame_d = at_last;
            grant_d = arb_grant;
            advance = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
        slot_d  = '0;
        grant_d = '0;
      end
    endcase

    if (clear) begin
      state_d = IDLE;
      div_d   = '0;
      slot_d  = '0;
      grant_d = '0;
      stb_d   = 1'b0;
      frame_d = 1'b0;
      advance = 1'b0;
    end
  end

  // State and datapath registers; Gray index is registered alongside binary.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      div_q   <= '0;
      per_q   <= '0;
      last_q  <= '0;
      slot_q  <= '0;
      gc_q    <= '0;
      grant_q <= '0;
      stb_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      per_q   <= per_d;
      last_q  <= last_d;
      slot_q  <= slot_d;
      gc_q    <= WIDTH'(bin2gray(32'(slot_d)));
      grant_q <= grant_d;
      stb_q   <= stb_d;
      frame_q <= frame_d;
    end
  end

  assign grant     = grant_q;
  assign slot_bin  = slot_q;
  assign slot_gc   = gc_q;
  assign slot_stb  = stb_q;
  assign frame_stb = frame_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_gc_slot_sched.sv
// Directed bench for gc_slot_sched; inputs change and outputs are sampled
// on the falling edge.
module tb_gc_slot_sched;

  logic       clk;
  logic       rstn;
  logic       start;
  logic       stop;
  logic       clear;
  logic [7:0] cfg_period;
  logic [7:0] cfg_last_slot;
  logic [3:0] req;
  logic [3:0] grant;
  logic [7:0] slot_bin;
  logic [7:0] slot_gc;
  logic       slot_stb;
  logic       frame_stb;
  logic       busy;

  int n_tests;
  int n_fail;

  gc_slot_sched #(
    .WIDTH (8),
    .N_REQ (4),
    .PER_W (8)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .stop          (stop),
    .clear         (clear),
    .cfg_period    (cfg_period),
    .cfg_last_slot (cfg_last_slot),
    .req           (req),
    .grant         (grant),
    .slot_bin      (slot_bin),
    .slot_gc       (slot_gc),
    .slot_stb      (slot_stb),
    .frame_stb     (frame_stb),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".grant"}, 32'(grant), 32'd0);
    check({tag, ".bin"}, 32'(slot_bin), 32'd0);
    check({tag, ".gc"}, 32'(slot_gc), 32'd0);
    check({tag, ".stb"}, 32'(slot_stb), 32'd0);
    check({tag, ".frame"}, 32'(frame_stb), 32'd0);
  endtask

  // Start pulse; returns while observing the first cycle of slot 0.
  task automatic do_start(input logic [7:0] p, input logic [7:0] l);
    start         = 1'b1;
    cfg_period    = p;
    cfg_last_slot = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_idle(tag);
  endtask

  initial begin
    logic [7:0] gtbl [4];
    logic [3:0] rr_exp [8];
    gtbl   = '{8'd0, 8'd1, 8'd3, 8'd2};
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0010};
    n_tests = 0;
    n_fail  = 0;
    rstn = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    cfg_period = '0; cfg_last_slot = '0; req = '0;

    // Reset
    #3 rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Basic timing: P=3, L=3, no requests
    do_start(8'd3, 8'd3);
    for (int i = 0; i <= 16; i++) begin
      check($sformatf("t1.stb[%0d]", i), 32'(slot_stb), 32'((i % 4) == 0));
      check($sformatf("t1.bin[%0d]", i), 32'(slot_bin), 32'((i / 4) % 4));
      check($sformatf("t1.gc[%0d]", i), 32'(slot_gc), 32'(gtbl[(i / 4) % 4]));
      check($sformatf("t1.frame[%0d]", i), 32'(frame_stb), 32'(i == 0 || i == 16));
      check($sformatf("t1.grant[%0d]", i), 32'(grant), 32'd0);
      check($sformatf("t1.busy[%0d]", i), 32'(busy), 32'd1);
      $display("[TB] t1 cycle %0d bin=%0d gc=%0d stb=%0d frame=%0d", i, slot_bin, slot_gc, slot_stb, frame_stb);
      @(negedge clk);
    end
    do_clear("t1.clear");

    // Round robin: P=0, L=7, all requesting, then 1010
    req = 4'b1111;
    do_start(8'd0, 8'd7);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rr.grant[%0d]", i), 32'(grant), 32'(rr_exp[i]));
      check($sformatf("rr.stb[%0d]", i), 32'(slot_stb), 32'd1);
      check($sformatf("rr.bin[%0d]", i), 32'(slot_bin), 32'(i));
      $display("[TB] rr slot %0d grant=%b", i, grant);
      if (i == 4) req = 4'b1010;
      @(negedge clk);
    end
    check("rr.wrap.bin", 32'(slot_bin), 32'd0);
    check("rr.wrap.frame", 32'(frame_stb), 32'd1);
    do_clear("rr.clear");

    // Held grant: P=5, req[2] drops mid-slot
    req = 4'b0100;
    do_start(8'd5, 8'd7);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("hold.grant[%0d]", i), 32'(grant), 32'b0100);
      check($sformatf("hold.stb[%0d]", i), 32'(slot_stb), 32'(i == 0));
      if (i == 2) req = 4'b0101;
      @(negedge clk);
    end
    check("hold.next.grant", 32'(grant), 32'b0001);
    check("hold.next.stb", 32'(slot_stb), 32'd1);
    check("hold.next.bin", 32'(slot_bin), 32'd1);
    $display("[TB] hold next slot grant=%b", grant);
    do_clear("hold.clear");

    // Stop and drain: P=1, L=3, stop during slot 1
    req = 4'b1111;
    do_start(8'd1, 8'd3);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain.busy[%0d]", i), 32'(busy), 32'd1);
      check($sformatf("drain.bin[%0d]", i), 32'(slot_bin), 32'(i / 2));
      check($sformatf("drain.stb[%0d]", i), 32'(slot_stb), 32'((i % 2) == 0));
      check($sformatf("drain.grant[%0d]", i), 32'(grant), 32'(4'b0001 << (i / 2)));
      stop = (i == 2);
      @(negedge clk);
      stop = 1'b0;
    end
    check_idle("drain.end");
    @(negedge clk);
    check_idle("drain.after");
    $display("[TB] drain finished busy=%0d", busy);

    // Clear mid slot 2
    do_start(8'd3, 8'd7);
    repeat (9) @(negedge clk);
    check("clr.bin.before", 32'(slot_bin), 32'd2);
    do_clear("clr.mid");

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check_idle("startstop");

    // start while running is ignored
    req = 4'b0000;
    do_start(8'd1, 8'd1);
    start = 1'b1; cfg_period = 8'd5; cfg_last_slot = 8'd0;
    @(negedge clk);
    start = 1'b0;
    check("rerun.stb1", 32'(slot_stb), 32'd0);
    @(negedge clk);
    check("rerun.stb2", 32'(slot_stb), 32'd1);
    check("rerun.bin2", 32'(slot_bin), 32'd1);
    check("rerun.frame2", 32'(frame_stb), 32'd0);
    repeat (2) @(negedge clk);
    check("rerun.bin4", 32'(slot_bin), 32'd0);
    check("rerun.frame4", 32'(frame_stb), 32'd1);
    do_clear("rerun.clear");

    // Async reset mid-run, pointer restarts at 0
    req = 4'b1111;
    do_start(8'd0, 8'd7);
    @(negedge clk);
    check("arst.pre.grant", 32'(grant), 32'b0010);
    #2 rstn = 1'b0;
    #1 check_idle("arst.now");
    @(negedge clk);
    rstn = 1'b1;
    do_start(8'd0, 8'd7);
    check("arst.post.grant", 32'(grant), 32'b0001);
    check("arst.post.busy", 32'(busy), 32'd1);
    do_clear("arst.clear");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gc_slot_sched.md
Name: gc_slot_sched

Overview:
TDM slot scheduler for the audio network link. It sequences a binary/Gray slot counter through a programmable frame, and shares each slot between up to N_REQ channel requesters using round-robin arbitration. It produces slot and frame strobes, a registered one-hot grant, and both binary and Gray slot indices. Downstream framers and CDC logic consume those indices.

Parameters:
WIDTH, 8, slot counter width; max frame length 2^WIDTH slots
N_REQ, 4, number of requesters (2..16)
PER_W, 8, width of the clocks-per-slot configuration

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begin scheduling
stop  input  1  single-cycle pulse; finish current frame, then idle
clear  input  1  synchronous abort to IDLE
cfg_period  input  PER_W  clocks per slot minus 1; latched at start
cfg_last_slot  input  WIDTH  index of last slot in frame; latched at start
req  input  N_REQ  per-requester slot request, level
grant  output  N_REQ  one-hot owner of current slot; 0 = slot unowned
slot_bin  output  WIDTH  current slot index, binary
slot_gc  output  WIDTH  current slot index, Gray: bin ^ (bin >> 1), registered in the same cycle as slot_bin
slot_stb  output  1  1-cycle pulse on the first cycle of every slot
frame_stb  output  1  1-cycle pulse on the first cycle of slot 0
busy  output  1  high in RUN and DRAIN

Behaviour:
- Reset (rstn=0, async): state=IDLE; all outputs 0; rr pointer=0; divider=0; latched cfg=0.
- States:
  - IDLE: start=1 and stop=0 -> RUN. If start and stop arrive together in IDLE, stop wins and the FSM stays in IDLE.
  - RUN: stop=1 -> DRAIN.
  - DRAIN: at the end of slot cfg_last_slot -> IDLE.
  - clear=1 in any state -> IDLE next cycle, with outputs, divider and rr pointer zeroed. clear has priority over start and stop.
- Start, accepted at cycle t:
  - cfg latched at t.
  - At t+1: busy=1, slot_bin=0, slot_gc=0, slot_stb=1, frame_stb=1.
  - grant is arbitrated from req sampled at t.
- Slot timing:
  - Divider counts 0..P, where P is the latched cfg_period.
  - Each slot lasts P+1 cycles. slot_stb asserts at t+1+k(P+1).
  - P=0 gives slot_stb high every cycle.
- Slot advance on the divider terminal:
  - slot_bin increments. If slot_bin==L (latched cfg_last_slot), it wraps to 0 and frame_stb pulses with slot_stb.
  - L=0 means every slot is slot 0, so frame_stb equals slot_stb.
- Arbitration: evaluated on the cycle before each slot_stb from the current req.
  - Search starts at the rr pointer and proceeds upward, mod N_REQ.
  - The winner's grant bit is registered with slot_stb and held constant for the entire slot.
  - After a grant to index i, pointer = (i+1) mod N_REQ.
  - No request: grant=0 and the pointer is unchanged.
  - Deasserting req mid-slot does not revoke grant.
- Commands while active: start in RUN/DRAIN is ignored; stop in DRAIN is ignored.
- DRAIN: slots continue normally.
  - On the divider terminal of slot L: state=IDLE, busy=0, grant=0, slot_bin=slot_gc=0, no strobe.
  - A stop during slot L in RUN completes that frame at the end of slot L.
- In IDLE, strobes are 0 and grant is 0.
- Arithmetic: the divider and slot counter use modulo compares only. The slot counter never exceeds L, and there are no width-overflow paths.

Decomposition:
- Package gc_sched_pkg:
  - state enum {IDLE, RUN, DRAIN}, 2 bits
  - function bin2gray(WIDTH)
  - default parameter constants
- Sub-module gc_rr_arb, parameterised by N_REQ:
  - inputs: req, pointer, advance
  - outputs: one-hot grant_next and pointer_next, combinational plus pointer register
  - the FSM, divider and slot counter stay in gc_slot_sched

Test Plan:
- Reset and start: reset, then start with cfg_period=3, cfg_last_slot=3, req=4'b0000. Expect slot_stb at t+1,5,9,13,17; slot_bin 0,1,2,3,0; slot_gc 0,1,3,2,0; frame_stb at t+1 and t+17; grant=0 throughout.
- Round-robin: req=4'b1111, P=0, L=7. Expect grants 0001,0010,0100,1000,0001 on consecutive slots. Then req=4'b1010 from pointer 1 gives 0010,1000,0010.
- Held grant: P=5, req[2] deasserted mid-slot. Expect grant=0100 held all 6 cycles; the next slot skips 2.
- Stop and drain: L=3, stop during slot 1. Expect slots 2 and 3 to run with busy=1; at the end of slot 3, busy=0, grant=0, slot_bin=0, no frame_stb.
- Clear and simultaneous events: clear mid-slot 2 gives all outputs 0 the next cycle. start+stop in IDLE leaves busy=0. start in RUN has no effect on cfg or timing.
- Async reset mid-RUN: assert rstn=0 between edges. Outputs go to 0 immediately; after release and start, the rr pointer restarts at 0.
